uart_tx_arbiter: RTL and testbench

- Shares one UART transmitter between two requesters (host channel 0, host channel 1) so both can send bytes over the single link.
- Accepts bytes through a valid/ready handshake per requester and arbitrates round-robin.
- Drives the transmitter through a start/done interface and holds the byte stable until the frame completes.
- Sits between the system-clock logic and the UART TX core; everything runs on clk_sis.

---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_tx_arbiter_if.sv | 27 ++
 rtl/uart_tx_arbiter_rr_arb2.sv | 24 ++
 rtl/uart_tx_arbiter.sv | 129 ++++++++++++
 tb/tb_uart_tx_arbiter.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared FSM encoding, data width default and source ids for the UART TX arbiter
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;

  localparam int DATA_W_DEF = 8;

  localparam logic SRC0 = 1'b0;
  localparam logic SRC1 = 1'b1;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// rtl/uart_tx_arbiter_if.sv - requester handshakes and UART TX start/done link
// master: the arbiter side; slave: requesters plus the UART TX core.
interface uart_tx_arbiter_if
  import uart_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
);
  logic              req0_valid;
  logic [DATA_W-1:0] req0_data;
  logic              req0_ready;
  logic              req1_valid;
  logic [DATA_W-1:0] req1_data;
  logic              req1_ready;
  logic              tx_start;
  logic [DATA_W-1:0] tx_data;
  logic              tx_done;

  modport master (
    input  req0_valid, req0_data, req1_valid, req1_data, tx_done,
    output req0_ready, req1_ready, tx_start, tx_data
  );

  modport slave (
    output req0_valid, req0_data, req1_valid, req1_data, tx_done,
    input  req0_ready, req1_ready, tx_start, tx_data
  );
endinterface

// File: rtl/uart_tx_arbiter_rr_arb2.sv
// rtl/uart_tx_arbiter_rr_arb2.sv - combinational two-way round-robin pick
module rr_arb2
  import uart_pkg::*;
(
  input  logic valid0,
  input  logic valid1,
  input  logic last_grant,
  output logic grant_valid,
  output logic grant_id
);

  assign grant_valid = valid0 | valid1;

  // On a tie the requester that did not win last time is picked.
  always_comb begin
    grant_id = SRC0;
    if (valid0 && valid1) begin
      grant_id = ~last_grant;
    end else if (valid1) begin
      grant_id = SRC1;
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin sharing of one UART TX between two byte requesters
// Optional tx_done timeout with sticky err is built when UART_ARB_TIMEOUT_EN is defined.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int CNT_W       = 16,
  parameter int TIMEOUT_CYC = 2048
)(
  input  logic                clk_sis,
  input  logic                rst,
  uart_tx_arbiter_if.master   bus,
  output logic                busy,
  output logic                grant_id,
  output logic                xfer_done,
  output logic                xfer_src,
  output logic [CNT_W-1:0]    cnt0,
  output logic [CNT_W-1:0]    cnt1,
  output logic                err
);

  state_t            state;
  logic              last_grant;
  logic [DATA_W-1:0] data_q;
  logic              gid_q;
  logic              tx_start_q;
  logic              xfer_done_q;
  logic              xfer_src_q;
  logic              pick_valid;
  logic              pick_id;
  logic              accept;
  logic              timeout_hit;

  rr_arb2 u_rr (
    .valid0      (bus.req0_valid),
    .valid1      (bus.req1_valid),
    .last_grant  (last_grant),
    .grant_valid (pick_valid),
    .grant_id    (pick_id)
  );

  // Ready is the only same-cycle output: it must answer valid while still in IDLE.
  assign accept         = !rst && (state == IDLE) && pick_valid;
  assign bus.req0_ready = accept && (pick_id == SRC0);
  assign bus.req1_ready = accept && (pick_id == SRC1);

  assign bus.tx_start = tx_start_q;
  assign bus.tx_data  = data_q;
  assign busy         = (state != IDLE);
  assign grant_id     = gid_q;
  assign xfer_done    = xfer_done_q;
  assign xfer_src     = xfer_src_q;

`ifdef UART_ARB_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  logic [TO_W-1:0] to_cnt;
  logic            err_q;
  assign timeout_hit = (to_cnt == TO_W'(TIMEOUT_CYC - 1));
  assign err         = err_q;
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = TIMEOUT_CYC;
  assign timeout_hit    = 1'b0;
  assign err            = 1'b0;
`endif

  always_ff @(posedge clk_sis) begin
    if (rst) begin
      state       <= IDLE;
      last_grant  <= SRC1;
      data_q      <= '0;
      gid_q       <= SRC0;
      tx_start_q  <= 1'b0;
      xfer_done_q <= 1'b0;
      xfer_src_q  <= SRC0;
      cnt0        <= '0;
      cnt1        <= '0;
`ifdef UART_ARB_TIMEOUT_EN
      to_cnt      <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      tx_start_q  <= 1'b0;
      xfer_done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_valid) begin
            data_q     <= (pick_id == SRC1) ? bus.req1_data : bus.req0_data;
            gid_q      <= pick_id;
            tx_start_q <= 1'b1;
            state      <= START;
          end
        end
        START: begin
          state <= WAIT_DONE;
`ifdef UART_ARB_TIMEOUT_EN
          to_cnt <= '0;
`endif
        end
        WAIT_DONE: begin
          if (bus.tx_done) begin
            xfer_done_q <= 1'b1;
            xfer_src_q  <= gid_q;
            last_grant  <= gid_q;
            state       <= IDLE;
            if (gid_q == SRC0) begin
              if (cnt0 != '1) cnt0 <= cnt0 + CNT_W'(1);
            end else begin
              if (cnt1 != '1) cnt1 <= cnt1 + CNT_W'(1);
            end
          end else if (timeout_hit) begin
            // Abandon the frame and hand priority to the other requester.
            last_grant <= gid_q;
            state      <= IDLE;
`ifdef UART_ARB_TIMEOUT_EN
            err_q      <= 1'b1;
`endif
          end else begin
`ifdef UART_ARB_TIMEOUT_EN
            to_cnt <= to_cnt + TO_W'(1);
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - self-checking bench for uart_tx_arbiter with a cycle model of the arbitration rules
module tb_uart_tx_arbiter;
  import uart_pkg::*;

  localparam int DW   = 8;
  localparam int CW   = 4;
  localparam int TO   = 16;
  localparam int CMAX = (1 << CW) - 1;
`ifdef UART_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk_sis = 1'b0;
  logic rst     = 1'b1;
  always #5 clk_sis = ~clk_sis;

  uart_tx_arbiter_if #(.DATA_W(DW)) bus ();
  logic          busy, grant_id, xfer_done, xfer_src, err;
  logic [CW-1:0] cnt0, cnt1;

  uart_tx_arbiter #(.DATA_W(DW), .CNT_W(CW), .TIMEOUT_CYC(TO)) dut (
    .clk_sis   (clk_sis),
    .rst       (rst),
    .bus       (bus),
    .busy      (busy),
    .grant_id  (grant_id),
    .xfer_done (xfer_done),
    .xfer_src  (xfer_src),
    .cnt0      (cnt0),
    .cnt1      (cnt1),
    .err       (err)
  );

  int tests = 0;
  int fails = 0;

  // Model: phase 0 = idle, 1 = start cycle, 2 = waiting for the UART.
  int         m_phase;
  int         m_wait;
  int         m_cnt[2];
  logic       m_last, m_gid, m_xdone, m_xsrc, m_err;
  logic [7:0] m_data;
  bit         m_known = 1'b0;

  logic       e_rdy0, e_rdy1, e_start;
  logic       s_rdy0, s_rdy1, s_start, s_busy, s_xdone, s_xsrc, s_err, s_gid;
  logic [7:0] s_data;
  int         s_cnt0, s_cnt1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_wait = 0; m_cnt[0] = 0; m_cnt[1] = 0;
    m_last = 1'b1; m_gid = 1'b0; m_xdone = 1'b0; m_xsrc = 1'b0; m_err = 1'b0;
    m_data = 8'h00; m_known = 1'b1;
  endtask

  // One clock: drive inputs at negedge, compare against the model, advance the model.
  task automatic cyc(input logic r, input logic v0, input logic [7:0] d0,
                     input logic v1, input logic [7:0] d1, input logic dn);
    logic acc, win;
    @(negedge clk_sis);
    rst = r;
    bus.req0_valid = v0; bus.req0_data = d0;
    bus.req1_valid = v1; bus.req1_data = d1;
    bus.tx_done = dn;
    #1;
    acc     = m_known && !r && (m_phase == 0) && (v0 || v1);
    win     = (v0 && v1) ? ~m_last : v1;
    e_rdy0  = acc && !win;
    e_rdy1  = acc && win;
    e_start = m_known && (m_phase == 1);
    s_rdy0 = bus.req0_ready; s_rdy1 = bus.req1_ready; s_start = bus.tx_start;
    s_data = bus.tx_data; s_busy = busy; s_xdone = xfer_done; s_xsrc = xfer_src;
    s_err = err; s_gid = grant_id; s_cnt0 = int'(cnt0); s_cnt1 = int'(cnt1);
    if (m_known) begin
      check("req0_ready", s_rdy0, e_rdy0);
      check("req1_ready", s_rdy1, e_rdy1);
      check("tx_start", s_start, e_start);
      check("tx_data", s_data, m_data);
      check("busy", s_busy, m_phase != 0);
      check("grant_id", s_gid, m_gid);
      check("xfer_done", s_xdone, m_xdone);
      check("xfer_src", s_xsrc, m_xsrc);
      check("cnt0", s_cnt0, m_cnt[0]);
      check("cnt1", s_cnt1, m_cnt[1]);
      check("err", s_err, m_err);
    end
    m_xdone = 1'b0;
    if (r) begin
      model_reset();
    end else if (m_phase == 0) begin
      if (acc) begin
        m_data = win ? d1 : d0; m_gid = win; m_phase = 1;
      end
    end else if (m_phase == 1) begin
      m_phase = 2; m_wait = 0;
    end else if (dn) begin
      m_xdone = 1'b1; m_xsrc = m_gid; m_last = m_gid; m_phase = 0;
      if (m_cnt[m_gid] < CMAX) m_cnt[m_gid]++;
    end else if (TO_EN && m_wait == TO - 1) begin
      m_err = 1'b1; m_last = m_gid; m_phase = 0;
    end else begin
      m_wait++;
    end
  endtask

  task automatic do_reset();
    cyc(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    cyc(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
  endtask

  initial begin
    int         pend, n0, n1, nx;
    logic       rv0, rv1, dn, rr;
    logic [7:0] rd0, rd1;
    logic       q_src[$];
    logic [7:0] q_dat[$];
    logic [7:0] exp_dat[4];
    logic       exp_src[4];

    bus.req0_valid = 1'b0; bus.req0_data = 8'h00;
    bus.req1_valid = 1'b0; bus.req1_data = 8'h00;
    bus.tx_done = 1'b0;

    // Reset state and single request
    do_reset();
    cyc(1'b0, 1'b1, 8'h5B, 1'b0, 8'h00, 1'b0);
    check("single ready0", s_rdy0, 1'b1);
    check("single ready1", s_rdy1, 1'b0);
    check("reset busy", s_busy, 1'b0);
    check("reset cnt0", s_cnt0, 0);
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    check("single tx_start", s_start, 1'b1);
    check("single tx_data", s_data, 8'h5B);
    repeat (99) cyc(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    check("single xfer_done", s_xdone, 1'b1);
    check("single xfer_src", s_xsrc, 1'b0);
    check("single cnt0", s_cnt0, 1);

    // Simultaneous requests and fairness over four transfers
    do_reset();
    exp_dat = '{8'h5B, 8'h42, 8'hA1, 8'hC3};
    exp_src = '{1'b0, 1'b1, 1'b0, 1'b1};
    n0 = 0; n1 = 0; pend = 0; nx = 0;
    for (int i = 0; i < 80 && nx < 4; i++) begin
      dn = 1'b0;
      if (pend > 0) begin pend--; dn = (pend == 0); end
      cyc(1'b0, n0 < 2, (n0 == 0) ? 8'h5B : 8'hA1, n1 < 2, (n1 == 0) ? 8'h42 : 8'hC3, dn);
      if (s_rdy0) n0++;
      if (s_rdy1) n1++;
      if (s_start) begin q_dat.push_back(s_data); pend = 2; end
      if (s_xdone) begin q_src.push_back(s_xsrc); nx++; end
    end
    check("fair transfers", nx, 4);
    for (int i = 0; i < 4; i++) begin
      if (i < q_src.size()) check($sformatf("fair src[%0d]", i), q_src[i], exp_src[i]);
      if (i < q_dat.size()) check($sformatf("fair data[%0d]", i), q_dat[i], exp_dat[i]);
    end
    check("fair cnt0", s_cnt0, 2);
    check("fair cnt1", s_cnt1, 2);

    // Reset in WAIT_DONE, coinciding with tx_done
    do_reset();
    cyc(1'b0, 1'b1, 8'h77, 1'b0, 8'h00, 1'b0);
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    repeat (3) cyc(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    check("midrst busy before", s_busy, 1'b1);
    cyc(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    check("midrst busy", s_busy, 1'b0);
    check("midrst tx_start", s_start, 1'b0);
    check("midrst xfer_done", s_xdone, 1'b0);
    check("midrst cnt0", s_cnt0, 0);

    // Saturation: 2^CW + 2 transfers from requester 1
    do_reset();
    pend = 0; nx = 0;
    for (int i = 0; i < 300 && nx < CMAX + 3; i++) begin
      dn = 1'b0;
      if (pend > 0) begin pend--; dn = (pend == 0); end
      cyc(1'b0, 1'b0, 8'h00, 1'b1, 8'($urandom), dn);
      if (s_start) pend = 1;
      if (s_xdone) nx++;
    end
    check("sat transfers", nx, CMAX + 3);
    check("sat cnt1", s_cnt1, CMAX);
    check("sat cnt0", s_cnt0, 0);

`ifdef UART_ARB_TIMEOUT_EN
    do_reset();
    cyc(1'b0, 1'b1, 8'h11, 1'b0, 8'h00, 1'b0);
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    repeat (16) cyc(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    cyc(1'b0, 1'b0, 8'h00, 1'b1, 8'h22, 1'b0);
    check("timeout busy", s_busy, 1'b0);
    check("timeout err", s_err, 1'b1);
    check("timeout xfer_done", s_xdone, 1'b0);
    check("timeout ready1", s_rdy1, 1'b1);
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    check("after timeout xfer_done", s_xdone, 1'b1);
    check("after timeout src", s_xsrc, 1'b1);
    check("after timeout err", s_err, 1'b1);
`endif

    // Random traffic with spurious tx_done and occasional reset
    do_reset();
    rv0 = 1'b0; rv1 = 1'b0; rd0 = 8'h00; rd1 = 8'h00; pend = 0;
    for (int i = 0; i < 4000; i++) begin
      if (!rv0 && $urandom_range(0, 3) == 0) begin rv0 = 1'b1; rd0 = 8'($urandom); end
      if (!rv1 && $urandom_range(0, 3) == 0) begin rv1 = 1'b1; rd1 = 8'($urandom); end
      dn = 1'b0;
      if (pend > 0) begin pend--; dn = (pend == 0); end
      else if ($urandom_range(0, 31) == 0) dn = 1'b1;
      rr = ($urandom_range(0, 799) == 0);
      cyc(rr, rv0, rd0, rv1, rd1, dn);
      if (e_rdy0) rv0 = 1'b0;
      if (e_rdy1) rv1 = 1'b0;
      if (e_start) pend = $urandom_range(1, 12);
      if (rr) pend = 0;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
